// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared widths and FSM state encoding for the I2C slave controller
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/i2c_fsm_transition_detect.sv
// rtl/i2c_fsm_transition_detect.sv - registered rise/fall detector with aligned delayed level
module i2c_fsm_transition_detect (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic din_q;
    logic lvl_q;
    logic rise_q;
    logic fall_q;

    // Idle bus level is high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q  <= 1'b1;
            lvl_q  <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            din_q  <= din_i;
            lvl_q  <= din_q;
            rise_q <= din_q & ~lvl_q;
            fall_q <= ~din_q & lvl_q;
        end
    end

    // lvl_q carries the same two-cycle delay as the pulses.
    assign level_o = lvl_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// rtl/i2c_slave_ctrl.sv - 7-bit address I2C slave protocol controller with open-drain SDA enable
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rw,
    output logic                  busy,
    output logic                  addr_hit
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        end
    end

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_fsm_transition_detect u_scl_det (
        .clk     (clk),
        .rst     (rst),
        .din_i   (scl_sync_q[SYNC_STAGES-1]),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_fsm_transition_detect u_sda_det (
        .clk     (clk),
        .rst     (rst),
        .din_i   (sda_sync_q[SYNC_STAGES-1]),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    state_e                  state_q, state_d;
    logic [I2C_BYTE_W-1:0]   shift_q, shift_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    tx_req_q, tx_req_d;
    logic                    rw_q, rw_d;
    logic                    busy_q, busy_d;
    logic                    addr_hit_q, addr_hit_d;
    logic [I2C_BYTE_W-1:0]   byte_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            addr_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            addr_hit_q <= addr_hit_d;
        end
    end

    // In the ACK states cnt_q marks whether the 9th scl_rise has been seen;
    // in READ_ACK it marks a master ACK sampled on that rise.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        rw_d       = rw_q;
        busy_d     = busy_q;
        addr_hit_d = addr_hit_q;
        byte_in    = {shift_q[I2C_BYTE_W-2:0], sda_lvl};

        if (sda_fall && scl_lvl) begin
            state_d    = ST_ADDR;
            cnt_d      = '0;
            shift_d    = '0;
            busy_d     = 1'b1;
            addr_hit_d = 1'b0;
            sda_oe_d   = 1'b0;
        end else if (sda_rise && scl_lvl) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            busy_d     = 1'b0;
            addr_hit_d = 1'b0;
            sda_oe_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            if (shift_q[I2C_ADDR_W-1:0] == ADDR) begin
                                state_d    = ST_ADDR_ACK;
                                rw_d       = sda_lvl;
                                addr_hit_d = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_WRITE_ACK: begin
                    if (scl_rise) begin
                        cnt_d = 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            cnt_d = '0;
                            if (state_q == ST_WRITE_ACK || !rw_q) begin
                                state_d  = ST_WRITE;
                                sda_oe_d = 1'b0;
                            end else begin
                                state_d  = ST_READ;
                                tx_req_d = 1'b1;
                                shift_d  = tx_data;
                                sda_oe_d = ~tx_data[I2C_BYTE_W-1];
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d      = '0;
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            state_d    = ST_WRITE_ACK;
                        end
                    end
                end
                ST_READ: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d    = '0;
                            sda_oe_d = 1'b0;
                            state_d  = ST_READ_ACK;
                        end else begin
                            shift_d  = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                            sda_oe_d = ~shift_q[I2C_BYTE_W-2];
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_d = ST_IGNORE;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d    = '0;
                        tx_req_d = 1'b1;
                        shift_d  = tx_data;
                        sda_oe_d = ~tx_data[I2C_BYTE_W-1];
                        state_d  = ST_READ;
                    end
                end
                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign tx_req   = tx_req_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rw       = rw_q;
    assign busy     = busy_q;
    assign addr_hit = addr_hit_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb/tb_i2c_slave_ctrl.sv - scoreboard bench for the I2C slave controller
module tb_i2c_slave_ctrl;

    localparam int Q = 8;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       scl_in, sda_in;
    logic       sda_oe, tx_req, rx_valid, rw, busy, addr_hit;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_slave_ctrl #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rw       (rw),
        .busy     (busy),
        .addr_hit (addr_hit)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_rx_q[$];
    int         exp_tx_q[$];
    logic       exp_bit_q[$];
    logic       slave_slot = 1'b0;
    logic       rx_prev = 1'b0;
    logic       tx_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_c();
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(H);
        sda_m = 1'b0; wclk(H);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(H);
        sda_m = 1'b1; wclk(H);
    endtask

    task automatic bit_m(input logic b);
        sda_m = b;    wclk(Q);
        scl_m = 1'b1; wclk(H);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic bit_s(input logic e);
        sda_m = 1'b1;
        slave_slot = 1'b1;
        exp_bit_q.push_back(e);
        wclk(Q);
        scl_m = 1'b1; wclk(H);
        scl_m = 1'b0;
        slave_slot = 1'b0;
        wclk(Q);
    endtask

    task automatic byte_m(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bit_m(b[i]);
    endtask

    task automatic byte_s(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bit_s(b[i]);
    endtask

    // SDA monitor: slave-driven bit slots are checked at the SCL rising edge.
    always @(posedge scl_in) begin
        if (slave_slot) begin
            if (exp_bit_q.size() == 0) chk("sda_bit_unexpected", 32'd1, 32'd0);
            else chk("sda_bit", sda_in, exp_bit_q.pop_front());
        end
    end

    // Pulse monitor for rx_valid / tx_req.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_prev) chk("rx_valid_width", rx_prev, 1'b0);
            else if (exp_rx_q.size() == 0) chk("rx_valid_unexpected", rx_valid, 1'b0);
            else chk("rx_data", rx_data, exp_rx_q.pop_front());
        end
        if (tx_req) begin
            if (tx_prev) chk("tx_req_width", tx_prev, 1'b0);
            else if (exp_tx_q.size() == 0) chk("tx_req_unexpected", tx_req, 1'b0);
            else chk("tx_req", tx_req, exp_tx_q.pop_front());
        end
        rx_prev <= rx_valid;
        tx_prev <= tx_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        wclk(4);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_tx_req", tx_req, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rw", rw, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr_hit", addr_hit, 1'b0);
        rst = 1'b0;
        wclk(4);

        // write 0xA0, 0x3C
        start_c();
        chk("t1_busy", busy, 1'b1);
        byte_m(8'hA0); bit_s(1'b0);
        chk("t1_addr_hit", addr_hit, 1'b1);
        chk("t1_rw", rw, 1'b0);
        exp_rx_q.push_back(8'h3C);
        byte_m(8'h3C); bit_s(1'b0);
        stop_c();
        chk("t1_busy_stop", busy, 1'b0);
        chk("t1_addr_hit_stop", addr_hit, 1'b0);
        chk("t1_sda_oe", sda_oe, 1'b0);
        chk("t1_rx_data", rx_data, 8'h3C);

        // foreign address 0x51
        start_c();
        byte_m(8'hA2); bit_s(1'b1);
        chk("t2_addr_hit", addr_hit, 1'b0);
        chk("t2_busy", busy, 1'b1);
        byte_m(8'h55); bit_m(1'b1);
        chk("t2_sda_oe", sda_oe, 1'b0);
        stop_c();

        // read two bytes: ACK then NACK
        tx_data = 8'hC5;
        start_c();
        byte_m(8'hA1);
        exp_tx_q.push_back(1);
        bit_s(1'b0);
        chk("t3_rw", rw, 1'b1);
        byte_s(8'hC5);
        tx_data = 8'h0F;
        exp_tx_q.push_back(1);
        bit_m(1'b0);
        byte_s(8'h0F);
        bit_m(1'b1);
        chk("t3_sda_oe_nack", sda_oe, 1'b0);
        stop_c();

        // write then repeated START into a read
        start_c();
        byte_m(8'hA0); bit_s(1'b0);
        chk("t4_rw_w", rw, 1'b0);
        exp_rx_q.push_back(8'h11);
        byte_m(8'h11); bit_s(1'b0);
        start_c();
        chk("t4_addr_hit_rs", addr_hit, 1'b0);
        chk("t4_busy_rs", busy, 1'b1);
        tx_data = 8'h96;
        byte_m(8'hA1);
        exp_tx_q.push_back(1);
        bit_s(1'b0);
        chk("t4_addr_hit", addr_hit, 1'b1);
        chk("t4_rw_r", rw, 1'b1);
        byte_s(8'h96);
        bit_m(1'b1);
        stop_c();
        chk("t4_busy_stop", busy, 1'b0);

        // STOP after 4 data bits
        start_c();
        byte_m(8'hA0); bit_s(1'b0);
        bit_m(1'b1); bit_m(1'b1); bit_m(1'b1); bit_m(1'b1);
        stop_c();
        chk("t5_busy", busy, 1'b0);
        chk("t5_sda_oe", sda_oe, 1'b0);
        chk("t5_rx_data", rx_data, 8'h11);
        chk("t5_addr_hit", addr_hit, 1'b0);

        // reset while driving the address ACK
        start_c();
        byte_m(8'hA0);
        sda_m = 1'b1;
        wclk(Q);
        chk("t6_ack_drive", sda_oe, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_sda_oe_async", sda_oe, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_addr_hit", addr_hit, 1'b0);
        chk("t6_rw", rw, 1'b0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wclk(4);
        rst = 1'b0;
        wclk(4);

        // normal write after reset
        start_c();
        byte_m(8'hA0); bit_s(1'b0);
        exp_rx_q.push_back(8'h5A);
        byte_m(8'h5A); bit_s(1'b0);
        stop_c();
        chk("t7_rx_data", rx_data, 8'h5A);
        chk("t7_busy", busy, 1'b0);

        wclk(8);
        chk("rx_queue_empty", exp_rx_q.size(), 0);
        chk("tx_queue_empty", exp_tx_q.size(), 0);
        chk("bit_queue_empty", exp_bit_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_ctrl.md
# i2c_slave_ctrl

I2C slave protocol controller for 7-bit addressing, built around two edge-detector instances (SCL, SDA). Detects START/STOP and repeated START, shifts address and data bits on SCL rising edges, and drives ACK/read data onto SDA on SCL falling edges via an open-drain enable. Sits between the bus pads and the register/FIFO logic, which exchange bytes over a simple pulse interface.

## Interface
- ADDR, 7'h50, own slave address
- SYNC_STAGES, 2, input synchronizer depth for scl_in/sda_in (≥2)
- clk  in  1  system clock, must be ≥10× SCL frequency
- rst  in  1  asynchronous, active-high reset
- scl_in  in  1  raw SCL pad level
- sda_in  in  1  raw SDA pad level
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release
- tx_data  in  8  byte to return on a read; sampled on tx_req
- tx_req  out  1  one-cycle pulse: tx_data sampled this cycle
- rx_data  out  8  last byte written by master
- rx_valid  out  1  one-cycle pulse: rx_data updated
- rw  out  1  R/W bit of the last matched address byte
- busy  out  1  1 between START and STOP (any address)
- addr_hit  out  1  1 from matched-address ACK until STOP/repeated START

## Operation
- Reset: all outputs 0, state IDLE, shift register and bit counter 0.
- Edge pulses: scl_rise/scl_fall/sda_rise/sda_fall from the detectors; SCL/SDA levels for qualification are synchronized levels delayed to align with the detector pulses.
- START: sda_fall while SCL high → state ADDR, bit count 0, busy=1, addr_hit=0, sda_oe=0. Valid in any state (repeated START).
- STOP: sda_rise while SCL high → IDLE, busy=0, addr_hit=0, sda_oe=0. Valid in any state; overrides any in-progress byte (no rx_valid).
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- ADDR: shift SDA MSB-first on each scl_rise; after 8th, compare [7:1] with ADDR. Match → ADDR_ACK, rw latched, addr_hit=1. Mismatch → IGNORE.
- ADDR_ACK: next scl_fall sets sda_oe=1; held through 9th scl_rise; on following scl_fall: rw=0 → WRITE, sda_oe=0; rw=1 → READ, tx_req pulse, load tx_data, sda_oe=~tx_data[7].
- WRITE: 8 bits sampled on scl_rise; on 8th, rx_data updated, rx_valid pulse, → WRITE_ACK. Always ACKs: sda_oe=1 on next scl_fall, released on the scl_fall after the 9th scl_rise, → WRITE.
- READ: on each scl_fall shift out next bit (sda_oe = ~bit); after 8th bit's scl_fall, sda_oe=0, → READ_ACK.
- READ_ACK: sample SDA on 9th scl_rise. Low (ACK) → on next scl_fall tx_req pulse, load tx_data, drive bit 7, → READ. High (NACK) → IGNORE.
- IGNORE: sda_oe=0, wait for START or STOP.
- START and STOP are checked before data-bit handling in the same cycle; a coincident scl edge is ignored.

## Timing
- Detector latency: 2 clk from synchronized level change to pulse; total pad→pulse latency SYNC_STAGES+2 clk.
- sda_oe changes 1 clk after the qualifying scl_fall pulse; rx_valid/tx_req asserted 1 clk after the qualifying scl pulse, exactly 1 clk wide.
- addr_hit, busy, rw are levels; rw holds its value past STOP until the next matched address.
- Reset mid-transfer: immediate IDLE, sda_oe=0 asynchronously; resumes only at the next START.

## Structure
- Package i2c_pkg: state encoding constants, I2C_ADDR_W=7, I2C_BYTE_W=8.
- Sub-modules: two instances of i2c_fsm_transition_detect (SCL and SDA); synchronizer inline.
- Single always_ff/always_comb FSM plus 8-bit shift register and 4-bit bit counter.

## Test plan
- Write 0xA0 (addr 0x50, W), data 0x3C, STOP → ACK low on both 9th clocks; rx_data=0x3C, one rx_valid pulse; busy low after STOP.
- Address 0x51 W → no ACK (sda_oe stays 0), state IGNORE; following write data produces no rx_valid.
- Read 0xA1, tx_data=0xC5, master ACK then NACK with tx_data=0x0F → bits 1100_0101 then 0000_1111 on SDA; two tx_req pulses; sda_oe=0 after NACK.
- Write 0xA0, 0x11, repeated START, 0xA1 read → rx_valid once for 0x11, rw=1, addr_hit reasserted, read byte driven.
- STOP after 4 data bits of a write → no rx_valid, IDLE, sda_oe=0.
- Assert rst during ADDR_ACK while sda_oe=1 → sda_oe=0 same cycle; all outputs 0; next valid transaction behaves normally.
